// File: rtl/aes_pkg.sv
// Shared AES types, the GF(2^8) helpers used by MixColumns and the
// column-major byte addressing helper.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_word_t;
   typedef logic [7:0]   aes_byte_t;

   // Reduction constant for x^8 + x^4 + x^3 + x + 1 (the x^8 term is implicit).
   localparam aes_byte_t AES_POLY = 8'h1b;

   // Multiply by x (i.e. by 2) in GF(2^8).
   function automatic aes_byte_t xtime(input aes_byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   // Multiply by x+1 (i.e. by 3) in GF(2^8).
   function automatic aes_byte_t gmul3(input aes_byte_t x);
      return xtime(x) ^ x;
   endfunction

   // MSB position of state byte s[r][c]; the byte is [byte_msb(r,c) -: 8].
   // Byte k = 4c+r sits at bits [127-8k -: 8] (byte 0 in the top bits).
   function automatic int byte_msb(input int r, input int c);
      return 127 - 8 * (4 * c + r);
   endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns on a single 32-bit column; a0 is the top byte [31:24].
// Purely combinational.
module aes_mix_column
   import aes_pkg::*;
(
   input  aes_word_t col_in,
   output aes_word_t col_out
);

   aes_byte_t a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   // Fixed circulant matrix {2,3,1,1} applied to the column.
   always_comb begin
      col_out = {xtime(a0) ^ gmul3(a1) ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ gmul3(a3),
                 gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
   end

endmodule

// File: rtl/aes_round_linear.sv
// Linear back half of an AES-128 encryption round:
// ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey,
// followed by a single output register.
//
// Handshake: in_valid qualifies state_in/round_key/final_round for the
// current cycle. There is no ready; every valid input is accepted, one per
// clock. out_valid is high for exactly one cycle per accepted input, one
// clock later; while it is low state_out keeps its last value.
module aes_round_linear
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       final_round,
   input  aes_state_t round_key,
   input  aes_state_t state_in,
   output logic       out_valid,
   output aes_state_t state_out
);

   aes_state_t shifted;
   aes_state_t mixed;
   aes_state_t result;
   aes_word_t  mix_col [4];

   // ShiftRows: row r rotates left by r bytes, s'[r][c] = s[r][(c+r) mod 4].
   always_comb begin
      shifted = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            shifted[byte_msb(r, c) -: 8] = state_in[byte_msb(r, (c + r) % 4) -: 8];
         end
      end
   end

   // One MixColumns unit per column; column 0 occupies the top 32 bits.
   for (genvar c = 0; c < 4; c++) begin : g_mix
      aes_mix_column u_mix (
         .col_in  (shifted[127 - 32 * c -: 32]),
         .col_out (mix_col[c])
      );
   end

   // Reassemble the mixed columns and apply AddRoundKey.
   always_comb begin
      mixed  = {mix_col[0], mix_col[1], mix_col[2], mix_col[3]};
      result = (final_round ? shifted : mixed) ^ round_key;
   end

   // Output register: load on in_valid, otherwise hold data and drop valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_out <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         state_out <= result;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_round_linear.sv
// Self-checking bench for aes_round_linear: directed FIPS-197 vectors,
// throughput, reset behaviour and randomized traffic against a reference
// model built from a generic GF(2^8) multiply and a 4x4 byte matrix.
module tb_aes_round_linear;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         final_round;
   logic [127:0] round_key;
   logic [127:0] state_in;
   logic         out_valid;
   logic [127:0] state_out;

   int n_assert = 0;
   int n_fail   = 0;

   // Scoreboard state.
   logic [127:0] exp_q[$];
   logic [127:0] last_exp;

   localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] R1_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] R1_MC   = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] FR_IN   = 128'he9098972cb31075f3d327d94af2e2cb5;
   localparam logic [127:0] FR_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FR_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] MC_IN   = 128'hdbc6015cf213c601010a53c6c6012245;
   localparam logic [127:0] MC_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

   aes_round_linear dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .final_round (final_round),
      .round_key   (round_key),
      .state_in    (state_in),
      .out_valid   (out_valid),
      .state_out   (state_out)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------

   // Shift-and-add multiply with reduction by 0x11b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] st,
                                              input logic [127:0] key,
                                              input logic fr);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   m [4][4];
      logic [7:0]   coef [4];
      logic [127:0] o;
      coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
      for (int k = 0; k < 16; k++) s[k % 4][k / 4] = st[127 - 8 * k -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (fr) m[r][c] = t[r][c];
            else begin
               m[r][c] = 8'h00;
               for (int j = 0; j < 4; j++)
                  m[r][c] = m[r][c] ^ gf_mul(coef[(j - r + 4) % 4], t[j][c]);
            end
         end
      end
      o = '0;
      for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = m[k % 4][k / 4];
      return o ^ key;
   endfunction

   // ---------------- checking ----------------

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Driver: present one cycle of inputs (called #1 after a rising edge),
   // update the scoreboard, wait for the edge and check the outputs.
   task automatic send(input logic v, input logic [127:0] st, input logic [127:0] key,
                       input logic fr, input logic [127:0] exp, input string tag);
      logic exp_v;
      logic [127:0] exp_s;
      in_valid    = v;
      state_in    = st;
      round_key   = key;
      final_round = fr;
      if (reset) begin
         exp_q.delete();
         last_exp = '0;
         exp_v    = 1'b0;
      end else begin
         if (v) exp_q.push_back(exp);
         exp_v = v;
      end
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {127'h0, out_valid}, {127'h0, exp_v});
      if (exp_v && exp_q.size() > 0) begin
         exp_s    = exp_q.pop_front();
         last_exp = exp_s;
      end else begin
         exp_s = last_exp;
      end
      check({tag, "_data"}, state_out, exp_s);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [127:0] rs, rk;
      logic         rf, rv;
      int           n_sent;
      int           n_cyc;

      reset       = 1'b1;
      in_valid    = 1'b0;
      final_round = 1'b0;
      round_key   = '0;
      state_in    = '0;
      last_exp    = '0;
      @(posedge clk);
      #1;

      // Reset state, with garbage on the unused inputs.
      send(1'b0, {4{$urandom}}, {4{$urandom}}, 1'b1, '0, "reset_idle");
      reset = 1'b0;

      // Combinational probes for the round-1 vector before it is clocked.
      in_valid    = 1'b1;
      state_in    = R1_IN;
      round_key   = R1_KEY;
      final_round = 1'b0;
      #1;
      check("probe_shiftrows", dut.shifted, R1_SR);
      check("probe_mixcolumns", dut.mixed, R1_MC);

      // Single round-1 transaction, then idle.
      send(1'b1, R1_IN, R1_KEY, 1'b0, R1_OUT, "round1");
      send(1'b0, '0, '0, 1'b0, '0, "round1_idle");

      // Final round on its own.
      send(1'b1, FR_IN, FR_KEY, 1'b1, FR_OUT, "final");
      send(1'b0, '0, '0, 1'b0, '0, "final_idle");

      // MixColumns isolation with a zero key.
      send(1'b1, MC_IN, '0, 1'b0, MC_OUT, "mixcol");

      // Back-to-back throughput, then hold.
      send(1'b1, R1_IN, R1_KEY, 1'b0, R1_OUT, "tput_a");
      send(1'b1, FR_IN, FR_KEY, 1'b1, FR_OUT, "tput_b");
      send(1'b0, {4{$urandom}}, {4{$urandom}}, 1'b0, '0, "tput_hold");
      send(1'b0, {4{$urandom}}, {4{$urandom}}, 1'b1, '0, "tput_hold2");

      // Reset wins over a simultaneous valid input.
      reset = 1'b1;
      send(1'b1, R1_IN, R1_KEY, 1'b0, R1_OUT, "reset_drop");
      reset = 1'b0;
      send(1'b1, R1_IN, R1_KEY, 1'b0, R1_OUT, "post_reset");

      // Reset mid-stream discards the in-flight result.
      send(1'b1, FR_IN, FR_KEY, 1'b1, FR_OUT, "pre_flush");
      reset = 1'b1;
      send(1'b1, MC_IN, '0, 1'b0, MC_OUT, "flush");
      reset = 1'b0;
      send(1'b0, '0, '0, 1'b0, '0, "flush_idle");

      // Randomized traffic with occasional idle cycles.
      n_sent = 0;
      n_cyc  = 0;
      while (n_sent < 1000 && n_cyc < 5000) begin
         rs = {$urandom, $urandom, $urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         rf = 1'($urandom_range(0, 3) == 0);
         rv = 1'($urandom_range(0, 7) != 0);
         send(rv, rs, rk, rf, ref_round(rs, rk, rf), "random");
         if (rv) n_sent++;
         n_cyc++;
      end
      n_assert++;
      assert (n_sent == 1000) else begin
         n_fail++;
         $error("FAIL random_count: observed %0d expected %0d", n_sent, 1000);
      end
      send(1'b0, '0, '0, 1'b0, '0, "drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
